// File: rtl/jk_seq_pkg.sv
// ============================================================================
// Module   : jk_seq_pkg
// Purpose  : Shared command, state and direction encodings for jk_count_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_seq_pkg;

  typedef logic [1:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_LOAD_LIMIT = 2'b00;
  localparam op_t OP_LOAD_COUNT = 2'b01;
  localparam op_t OP_START      = 2'b10;
  localparam op_t OP_STOP       = 2'b11;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// ============================================================================
// Module   : jk_cell
// Purpose  : Single JK flip-flop storage cell with synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      case ({j_i, k_i})
        2'b10:   q_q <= 1'b1;
        2'b01:   q_q <= 1'b0;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/jk_count_sequencer.sv
// ============================================================================
// Module   : jk_count_sequencer
// Purpose  : Sequences a bank of JK cells as an up/down counter with a limit.
//            Optional auto-reload mode selected by JK_SEQ_AUTO_RELOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_count_sequencer
  import jk_seq_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             cmd_err
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] j_mask, k_mask;
  logic [WIDTH-1:0] terminal, next_cnt;
  logic             accept;
`ifdef JK_SEQ_AUTO_RELOAD_EN
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] reload;
`endif

  assign cmd_ready = ~reset & (state_q != S_DONE);
  assign accept    = cmd_valid & cmd_ready;
  assign terminal  = (dir_q == DIR_UP) ? limit_q : '0;
  assign next_cnt  = (dir_q == DIR_UP) ? count + C_ONE : count - C_ONE;
`ifdef JK_SEQ_AUTO_RELOAD_EN
  assign reload    = (dir_q == DIR_UP) ? '0 : limit_q;
`endif

  // The cells are only ever driven through J/K: loads use J=d/K=~d, counting
  // uses toggle masks, and untouched cells see J=K=0.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    j_mask  = '0;
    k_mask  = '0;
`ifdef JK_SEQ_AUTO_RELOAD_EN
    wrap_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD_LIMIT: limit_d = cmd_data;
            OP_LOAD_COUNT: begin
              j_mask = cmd_data;
              k_mask = ~cmd_data;
            end
            OP_START: begin
              dir_d   = cmd_data[0];
              state_d = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (accept && (cmd_op == OP_STOP)) begin
          state_d = S_IDLE;
        end else begin
          err_d = accept;
          if (count == terminal) begin
`ifdef JK_SEQ_AUTO_RELOAD_EN
            j_mask = count ^ reload;
            k_mask = count ^ reload;
            wrap_d = 1'b1;
`else
            state_d = S_DONE;
`endif
          end else begin
            j_mask = count ^ next_cnt;
            k_mask = count ^ next_cnt;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      limit_q <= LIMIT_RST;
      dir_q   <= DIR_UP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

`ifdef JK_SEQ_AUTO_RELOAD_EN
  always_ff @(posedge clk) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end
  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .j_i   (j_mask[gi]),
        .k_i   (k_mask[gi]),
        .q_o   (count[gi])
      );
    end
  endgenerate

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign cmd_err = err_q;

endmodule

`default_nettype wire

// File: doc/jk_count_sequencer.md
Name: jk_count_sequencer

Overview:
- Controller that sequences a WIDTH-bit bank of JK flip-flop cells as a programmable up/down counter with a terminal limit.
- Accepts load/start/stop commands over a valid/ready interface and drives each cell's J/K inputs.
- Reports count, busy, and completion.
- Sits between a host FSM/testbench and the JK storage cells; it is the sole driver of their J/K lines.

Parameters:
- WIDTH, 4, counter/limit bit width (>=2)
- LIMIT_RST, {WIDTH{1'b1}}, limit register value after reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command can be accepted this cycle
- cmd_op  input  2  00 LOAD_LIMIT, 01 LOAD_COUNT, 10 START, 11 STOP
- cmd_data  input  WIDTH  operand for LOAD_*; for START, bit0 = direction (1 up, 0 down)
- count  output  WIDTH  current JK bank contents
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- wrap  output  1  one-cycle pulse on auto-reload (feature only; tied 0 otherwise)
- cmd_err  output  1  one-cycle pulse when an accepted command is rejected

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high, named reset.
- Reset values:
  - state IDLE, count 0, limit LIMIT_RST, dir up.
  - done, wrap, cmd_err 0; busy 0.
  - cmd_ready 0 while reset is high.
- Handshake:
  - Transfer occurs on a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = 1 in IDLE and RUN, 0 in DONE.
  - cmd_ready is combinational from registered state only; it never depends on cmd_valid.
- Terminal value: limit when dir up, 0 when dir down.
- States:
  - IDLE:
    - LOAD_LIMIT: limit <= cmd_data.
    - LOAD_COUNT: cells load cmd_data via J=d, K=~d.
    - START: dir <= cmd_data[0]; state <= RUN.
    - STOP: no-op, no error.
  - RUN:
    - Each edge: if count == terminal, state <= DONE and count holds.
    - Otherwise count <= count±1 mod 2^WIDTH. J/K derived as T-style toggles, J=K=toggle mask.
    - Accepted STOP: state <= IDLE, count holds. STOP has priority over the terminal check in the same cycle.
    - Accepted LOAD_* or START: dropped, cmd_err pulses next cycle.
  - DONE: done = 1 for exactly one cycle; state <= IDLE.
- Latency: START accepted at edge t → first count change at edge t+1 → DONE entered on the edge after count reaches terminal.
- Boundaries:
  - START with count already at terminal: one RUN cycle, then DONE, no count change.
  - Up with count > limit: counts through wrap (all-ones → 0) until reaching limit.
  - limit = 0 with dir up: behaves like the terminal case when count = 0.
- Reset mid-RUN: next edge returns all reset values; no done pulse.
- Cell hold: cells not being changed receive J=K=0.

Optional Feature:
- Macro: JK_SEQ_AUTO_RELOAD_EN.
- Defined: on reaching terminal in RUN, count reloads on the next edge (0 when up, limit when down), state stays RUN, wrap pulses that cycle, DONE is never entered. Only STOP or reset leaves RUN.
- Undefined: wrap tied 0; behaviour exactly as above.

Decomposition:
- Shared package jk_seq_pkg:
  - cmd_op encodings (OP_LOAD_LIMIT, OP_LOAD_COUNT, OP_START, OP_STOP)
  - state enum (S_IDLE, S_RUN, S_DONE)
  - direction constants DIR_UP/DIR_DN
- One sub-module, jk_cell: single JK flip-flop with synchronous active-high reset.
  - Behaviour: J&~K set, ~J&K clear, J&K toggle, 00 hold.
  - Instantiated WIDTH times via generate.

Test Plan:
- Reset then LOAD_LIMIT 3, START up → count 1,2,3 on successive edges; done pulses one cycle later; busy high 4 cycles; cmd_ready low only in the DONE cycle.
- LOAD_COUNT 5, START down → count 4,3,2,1,0 then done; count stays 0 in IDLE.
- LOAD_LIMIT 2, LOAD_COUNT 14, START up (WIDTH 4) → 15,0,1,2 then done.
- START up, STOP after count = 2 → IDLE next edge, count holds 2, no done; LOAD_COUNT while RUN → cmd_err pulse, count unaffected.
- Assert reset while count = 6 in RUN → next edge count 0, busy 0, limit 15, cmd_ready 0 while reset high.
- JK_SEQ_AUTO_RELOAD_EN, limit 2, START up → 1,2,0,1,2,0…; wrap pulses at each reload; done never high; STOP ends the run.
